mux_stream_arbiter: RTL and testbench
=====================================

Name: mux_stream_arbiter

Overview:
Parametrised successor to the fixed 4-way 16-bit multiplexer: selects one of CHANNELS input streams of WIDTH bits and forwards it through a single registered output stage with valid/ready handshake. Two modes are supported. In fixed mode the external select picks the channel. In round-robin mode the block arbitrates fairly among the requesting channels. It sits between multiple producers (e.g. memory-mapped peripherals) and a single consumer on the Hack data path.

Parameters:
WIDTH, 16, data width per channel in bits (>=1)
CHANNELS, 4, number of input channels (>=2)
SEL_WIDTH is a localparam, not overridable: max(1, clog2(CHANNELS)).

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous active-low reset
in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel valid
in_ready  output  CHANNELS  per-channel ready (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_WIDTH  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_channel  output  SEL_WIDTH  registered index of the channel that produced out_data
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_channel=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has top priority after reset.
  - in_ready=0 for every channel while reset_n=0.
- Reset mid-transfer discards the held word. No partial state survives.
- load_en = ~out_valid | out_ready, i.e. the output register is empty or is being drained this cycle.
- Grant logic (combinational):
  - Fixed mode: grant is valid only if sel < CHANNELS and in_valid[sel]=1; then grant = sel.
  - Fixed mode, sel >= CHANNELS: no grant, and all in_ready stay 0.
  - Round-robin mode: grant = the first i with in_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo CHANNELS, with wrap-around.
  - No valid input gives no grant.
- in_ready[i] = reset_n & load_en & grant_valid & (grant==i). At most one in_ready is high in any cycle (one-hot or zero).
- A transfer occurs on channel i when in_valid[i] & in_ready[i]. At that edge:
  - out_data <= channel i data.
  - out_channel <= i.
  - out_valid <= 1.
  - last_grant <= i. The pointer updates in both modes, so fairness resumes from the last served channel when mode switches.
- Drain without a new grant (out_valid & out_ready, no input transfer): out_valid <= 0. out_data and out_channel hold their last values.
- Simultaneous drain and load (out_valid & out_ready, plus a grant): the new word is loaded and out_valid stays 1. Full throughput is one word per cycle.
- Stall (out_valid & ~out_ready): out_data, out_channel and out_valid hold; all in_ready=0.
- Latency: one cycle from an input handshake to out_valid.
- mode/sel changes affect only the next grant. A word already held in the output register is never altered.
- Producers must not make in_valid depend on in_ready. Once asserted, in_valid and that channel's in_data hold until accepted.
- No arithmetic. Data passes through bit-exact, with no width conversion.

Test Plan:
The bench uses CHANNELS=4, WIDTH=16 and data a=16'h5500, b=16'hAA00, c=16'h0055, d=16'h00AA on channels 0-3.
1. Fixed mode, all valid, out_ready=1, sel stepped 0,1,2,3 each cycle -> out_data sequence a,b,c,d with out_channel 0,1,2,3, one cycle after each sel. in_ready is one-hot on the selected channel only.
2. Round-robin, all four valid continuously, out_ready=1 after reset -> grants 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1 from the 2nd cycle.
3. Round-robin, only channels 1 and 3 valid -> alternating out_data b,d,b,d; channels 0 and 2 never ready.
4. Backpressure: hold out_ready=0 for 3 cycles after the first load of a -> out_data=5500 and out_valid=1 stable; all in_ready=0. Release -> next word b appears the following cycle.
5. Fixed mode, sel=2, in_valid[2]=0, others valid -> no transfer, out_valid falls to 0 after drain. Raise in_valid[2] -> out_data=0055 one cycle later.
6. Assert reset_n=0 for one cycle while out_valid=1 holding d -> out_valid=0, out_data=0, out_channel=0 next cycle. With round-robin and all valid, the first grant is channel 0.

Source files
------------

// File: rtl/mux_stream_arbiter.sv
// CHANNELS-way stream selector: fixed-select or round-robin grant feeding one
// registered valid/ready output stage.

module mux_stream_arbiter_lane #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2,
    parameter int IDX       = 0
) (
    input  logic                 take,
    input  logic [SEL_WIDTH-1:0] grant,
    input  logic [WIDTH-1:0]     data,
    output logic                 ready,
    output logic [WIDTH-1:0]     data_sel
);
    // data_sel is zero unless this lane is granted, so lanes can be OR-combined
    assign ready    = take && (grant == SEL_WIDTH'(IDX));
    assign data_sel = ready ? data : '0;
endmodule

module mux_stream_arbiter #(
    parameter  int WIDTH     = 16,
    parameter  int CHANNELS  = 4,
    localparam int SEL_WIDTH = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_WIDTH-1:0]      sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]      out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);
    logic [SEL_WIDTH-1:0]             last_grant;
    logic [SEL_WIDTH-1:0]             rr_grant, grant;
    logic                             rr_valid, fx_valid, grant_valid;
    logic                             load_en, take;
    logic [CHANNELS-1:0][WIDTH-1:0]   lane_data;
    logic [WIDTH-1:0]                 mux_data;

    assign load_en = ~out_valid | out_ready;

    // Scan starts just past the last served channel and wraps once around.
    always_comb begin
        int idx;
        rr_valid = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (!rr_valid && in_valid[idx]) begin
                rr_valid = 1'b1;
                rr_grant = SEL_WIDTH'(idx);
            end
        end
    end

    assign fx_valid    = (int'(sel) < CHANNELS) && in_valid[sel];
    assign grant       = mode ? rr_grant : sel;
    assign grant_valid = mode ? rr_valid : fx_valid;
    assign take        = reset_n & load_en & grant_valid;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        mux_stream_arbiter_lane #(
            .WIDTH     (WIDTH),
            .SEL_WIDTH (SEL_WIDTH),
            .IDX       (i)
        ) u_lane (
            .take     (take),
            .grant    (grant),
            .data     (in_data[i*WIDTH +: WIDTH]),
            .ready    (in_ready[i]),
            .data_sel (lane_data[i])
        );
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < CHANNELS; i++) mux_data |= lane_data[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            last_grant  <= SEL_WIDTH'(CHANNELS - 1);
        end else if (take) begin
            out_valid   <= 1'b1;
            out_data    <= mux_data;
            out_channel <= grant;
            last_grant  <= grant;
        end else if (out_ready) begin
            // drained with nothing new: keep data/channel, drop valid
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Directed table-driven bench for mux_stream_arbiter (4 x 16-bit).

module tb_mux_stream_arbiter;
    localparam int W = 16;
    localparam int C = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [C*W-1:0] in_data;
    logic [C-1:0]  in_valid;
    logic [C-1:0]  in_ready;
    logic          mode;
    logic [1:0]    sel;
    logic [W-1:0]  out_data;
    logic [1:0]    out_channel;
    logic          out_valid;
    logic          out_ready;

    logic [W-1:0]  d_ch [C];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign in_data = {d_ch[3], d_ch[2], d_ch[1], d_ch[0]};

    mux_stream_arbiter #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .sel         (sel),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  erdy;
        logic        evld;
        logic [15:0] edat;
        logic [1:0]  ech;
    } vec_t;

    vec_t vt [64];
    int   nv = 0;

    localparam logic [15:0] A = 16'h5500, B = 16'hAA00, CC = 16'h0055, D = 16'h00AA;

    task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic o, input logic [3:0] er, input logic ev,
                       input logic [15:0] ed, input logic [1:0] ec);
        vt[nv] = '{r, m, s, v, o, er, ev, ed, ec};
        nv++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [15:0] ed, input logic [1:0] ec);
        chk({tag, " out_valid"}, int'(out_valid), int'(ev));
        chk({tag, " out_data"}, int'(out_data), int'(ed));
        chk({tag, " out_channel"}, int'(out_channel), int'(ec));
    endtask

    initial begin
        d_ch[0] = A; d_ch[1] = B; d_ch[2] = CC; d_ch[3] = D;
        reset_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;

        // 1: fixed mode stepping sel
        add(0,0,0,4'b0000,1, 4'b0000,0,16'h0000,0);
        add(1,0,0,4'b1111,1, 4'b0001,1,A,0);
        add(1,0,1,4'b1111,1, 4'b0010,1,B,1);
        add(1,0,2,4'b1111,1, 4'b0100,1,CC,2);
        add(1,0,3,4'b1111,1, 4'b1000,1,D,3);
        // 2: round-robin, all valid
        add(0,1,0,4'b1111,1, 4'b0000,0,16'h0000,0);
        add(1,1,0,4'b1111,1, 4'b0001,1,A,0);
        add(1,1,0,4'b1111,1, 4'b0010,1,B,1);
        add(1,1,0,4'b1111,1, 4'b0100,1,CC,2);
        add(1,1,0,4'b1111,1, 4'b1000,1,D,3);
        add(1,1,0,4'b1111,1, 4'b0001,1,A,0);
        add(1,1,0,4'b1111,1, 4'b0010,1,B,1);
        // 3: round-robin, channels 1 and 3 only
        add(0,1,0,4'b1010,1, 4'b0000,0,16'h0000,0);
        add(1,1,0,4'b1010,1, 4'b0010,1,B,1);
        add(1,1,0,4'b1010,1, 4'b1000,1,D,3);
        add(1,1,0,4'b1010,1, 4'b0010,1,B,1);
        add(1,1,0,4'b1010,1, 4'b1000,1,D,3);
        // 4: backpressure
        add(0,1,0,4'b1111,1, 4'b0000,0,16'h0000,0);
        add(1,1,0,4'b1111,1, 4'b0001,1,A,0);
        add(1,1,0,4'b1111,0, 4'b0000,1,A,0);
        add(1,1,0,4'b1111,0, 4'b0000,1,A,0);
        add(1,1,0,4'b1111,0, 4'b0000,1,A,0);
        add(1,1,0,4'b1111,1, 4'b0010,1,B,1);
        // 5: fixed sel=2 with channel 2 idle, then raised
        add(1,0,2,4'b1011,1, 4'b0000,0,B,1);
        add(1,0,2,4'b1011,1, 4'b0000,0,B,1);
        add(1,0,2,4'b1111,1, 4'b0100,1,CC,2);
        // 6: reset while holding d, then round-robin restarts at channel 0
        add(1,0,3,4'b1111,1, 4'b1000,1,D,3);
        add(0,1,0,4'b1111,1, 4'b0000,0,16'h0000,0);
        add(1,1,0,4'b1111,1, 4'b0001,1,A,0);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            reset_n = vt[i].rst_n; mode = vt[i].mode; sel = vt[i].sel;
            in_valid = vt[i].vld; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), int'(in_ready), int'(vt[i].erdy));
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vt[i].evld, vt[i].edat, vt[i].ech);
        end

        // bit-exact pass-through of an all-ones word
        @(negedge clk);
        d_ch[1] = 16'hFFFF; mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        chk_out("allones", 1'b1, 16'hFFFF, 2'd1);

        // stall holds the word; ready must stay low
        @(negedge clk);
        out_ready = 1'b0; d_ch[1] = B;
        #1;
        chk("stall in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk_out("stall", 1'b1, 16'hFFFF, 2'd1);

        // reset during stall discards the held word
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        chk_out("rst_stall", 1'b0, 16'h0000, 2'd0);

        // pointer back at CHANNELS-1: lone channel 3 request is served next
        @(negedge clk);
        reset_n = 1'b1; mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
        #1;
        chk("post_rst in_ready", int'(in_ready), 4'b1000);
        @(posedge clk); #1;
        chk_out("post_rst", 1'b1, D, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
